// File: rtl/bcd_sseg_scan.sv
// Multiplexed BCD to seven-segment scanner.
// Frame-synchronous double buffer, leading-zero blanking, active-low outputs.
module bcd_sseg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                tick;
  logic                wrap;
  logic                boundary;

  logic [4*DIGITS-1:0] shadow_bcd;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] act_bcd;
  logic [DIGITS-1:0]   act_dp;
  logic                pending;

  logic [DIGITS-1:0]   zrun;
  logic [DIGITS-1:0]   hide;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_hide;
  logic [DIGITS-1:0]   scan_an;
  logic [DIGITS-1:0]   an_raw;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    unique case (code)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign tick     = (cnt == CW'(REFRESH_DIV - 1));
  assign wrap     = (idx == IW'(DIGITS - 1));
  assign boundary = tick && wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + CW'(1);
      if (tick) begin
        if (wrap) idx <= '0;
        else      idx <= idx + IW'(1);
      end
    end
  end

  // A load on the boundary bypasses the shadow so it is never a frame late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      act_bcd    <= '0;
      act_dp     <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        shadow_bcd <= bcd_in;
        shadow_dp  <= dp_in;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          act_bcd <= bcd_in;
          act_dp  <= dp_in;
        end else if (pending) begin
          act_bcd <= shadow_bcd;
          act_dp  <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // A lit decimal point ends the zero run from the top.
  always_comb begin
    logic run;
    run  = 1'b1;
    zrun = '0;
    hide = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run = run && (act_bcd[4*k +: 4] == 4'd0) && !act_dp[k];
      zrun[k] = run;
      hide[k] = (LZ_BLANK != 0) && (k > 0) && zrun[k];
    end
  end

  always_comb begin
    cur_code = '0;
    cur_dp   = 1'b0;
    cur_hide = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_code = act_bcd[4*k +: 4];
        cur_dp   = act_dp[k];
        cur_hide = hide[k];
      end
    end
  end

  always_comb begin
    scan_an = '1;
    if (!cur_hide) scan_an = ~(DIGITS'(1) << idx);
    an_next = tick ? scan_an : an_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_raw     <= '1;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      an_raw     <= an_next;
      an         <= blank ? '1 : an_next;
      if (tick) begin
        if (cur_hide) begin
          seg <= 7'h7F;
          dp  <= 1'b1;
        end else begin
          seg <= decode(cur_code);
          dp  <= ~cur_dp;
        end
      end
    end
  end

endmodule

// File: doc/bcd_sseg_scan.md
BCD_SSEG_SCAN -- requirements
Module: bcd_sseg_scan

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot, legal range >= 2.
REQ-003 The block SHALL have parameter LZ_BLANK, default 1: 1 blanks leading zeros, 0 shows all digits.
REQ-004 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port bcd_in, input, 4*DIGITS bits: digit k is bcd_in[4k+3:4k], where k=0 is the least significant digit.
REQ-007 Port dp_in, input, DIGITS bits: decimal point request per digit, 1 = lit.
REQ-008 Port load, input, 1 bit: one-cycle strobe that captures bcd_in and dp_in into the shadow register.
REQ-009 Port blank, input, 1 bit: 1 turns off every anode, combined into the registered outputs.
REQ-010 Port seg, output, 7 bits: segment cathodes, active-low; seg[0]=a through seg[6]=g.
REQ-011 Port dp, output, 1 bit: decimal point cathode, active-low.
REQ-012 Port an, output, DIGITS bits: digit anodes, active-low, one-hot-low when displaying.
REQ-013 Port frame_done, output, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-014 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick is asserted on the cycle the count equals REFRESH_DIV-1.
REQ-015 On tick, the digit index SHALL advance 0,1,...,DIGITS-1 and then wrap to 0.
REQ-016 A frame boundary SHALL be the tick on which the index wraps from DIGITS-1 to 0; frame_done SHALL be 1 on the cycle after that tick, for exactly one cycle.
REQ-017 load SHALL write the shadow register and set the pending flag; a later load before the boundary overwrites the shadow (last value wins).
REQ-018 At a frame boundary with pending=1, the shadow SHALL be copied to the active register and pending cleared; the display SHALL never mix old and new digits within one frame.
REQ-019 If load coincides with a frame boundary, the new bcd_in/dp_in SHALL go directly to the active register and pending SHALL end at 0.
REQ-020 seg, dp and an SHALL be registered and SHALL update one cycle after each tick; latency from tick to new an is 1 cycle.
REQ-021 Decode codes 0-9 to standard 7-segment patterns (active-low); codes 10-15 SHALL show a dash (only g lit, seg=7'b0111111).
REQ-022 With LZ_BLANK=1, digit k>0 SHALL be blanked (its anode high, seg all 1) when it and every higher digit are 0; digit 0 is never blanked by this rule.
REQ-023 A lit dp_in bit SHALL suppress leading-zero blanking of that digit and of all lower digits.
REQ-024 When blank=1, an SHALL be all 1 from the next cycle; scanning, the prescaler and frame_done SHALL continue unaffected.
REQ-025 seg and dp SHALL correspond to the digit whose anode is low in the same cycle.

Reset
REQ-026 While rst_n=0, all of the following SHALL hold: prescaler=0, index=0, shadow=0, active=0, pending=0, an all 1, seg=7'h7F, dp=1, frame_done=0.
REQ-027 After rst_n rises, the first anode SHALL go low one cycle after the first tick, i.e. at cycle REFRESH_DIV.
REQ-028 Reset asserted mid-frame SHALL discard pending and shadow data immediately, without waiting for a clock edge.

Verification (DIGITS=4, REFRESH_DIV=4, LZ_BLANK=1)
REQ-029 Apply load with bcd_in=16'h1234 and dp_in=0 after reset -> an cycles 1110,1101,1011,0111 at 4-cycle spacing; seg shows 4,3,2,1; frame_done pulses once per 16 cycles.
REQ-030 Load bcd_in=16'h0042 -> digits 3 and 2 blanked (an stays 1111 in their slots), 2 and 4 shown; then set dp_in=4'b0100 -> digit 2 shows 0 with dp=0.
REQ-031 Load 16'h1111, then mid-frame load 16'h2222 and 16'h3333 -> the current frame completes with 1s, the next frame shows all 3s, and 2 is never displayed.
REQ-032 Assert load of 16'h5678 on the boundary tick -> the next frame shows 5678 and pending=0.
REQ-033 Load digit code 4'hB -> seg=7'b0111111; assert blank for 10 cycles -> an=1111 while frame_done timing is unchanged.
REQ-034 Pulse rst_n low mid-frame with pending=1 -> outputs take the reset values asynchronously, and the display after release shows 0 in digit 0 only.
